// File: rtl/seq_alu_pkg.sv
// seq_alu shared types: opcode encoding, FSM states, iterative datapath mode.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'b00001,
    OP_SUB = 5'b00010,
    OP_AND = 5'b00011,
    OP_OR  = 5'b00100,
    OP_XOR = 5'b00101,
    OP_NOT = 5'b00110,
    OP_SHL = 5'b00111,
    OP_SHR = 5'b01000,
    OP_SAR = 5'b01001,
    OP_MUL = 5'b01011,
    OP_DIV = 5'b01100,
    OP_MOD = 5'b01101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef enum logic {
    IT_MUL = 1'b0,
    IT_DIV = 1'b1
  } iter_mode_t;

  function automatic logic is_multicycle(alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between operand fetch, seq_alu and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 10
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             s;
  logic             g;
  logic             z;
  logic             c;
  logic             err;

  modport master (
    output in_valid, opcode, op1, op2, out_ready,
    input  in_ready, out_valid, res, s, g, z, c, err
  );

  modport slave (
    input  in_valid, opcode, op1, op2, out_ready,
    output in_ready, out_valid, res, s, g, z, c, err
  );
endinterface

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: LSB-first shift-add multiply, restoring divide.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0] hi_q, lo_q, opd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  iter_mode_t       mode_q;

  logic [WIDTH-1:0] src_hi, src_lo, src_opd, nxt_hi, nxt_lo;
  iter_mode_t       src_mode;
  logic [WIDTH:0]   sum, rem;
  logic             qb;

  // One iteration step; the first step runs straight off the start operands
  // so that WIDTH steps complete in WIDTH cycles counting the start cycle.
  always_comb begin
    src_hi   = start ? '0 : hi_q;
    src_mode = start ? mode : mode_q;
    if (start) begin
      src_lo  = (mode == IT_MUL) ? b : a;
      src_opd = (mode == IT_MUL) ? a : b;
    end else begin
      src_lo  = lo_q;
      src_opd = opd_q;
    end
    sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opd} : '0);
    rem = {src_hi, src_lo[WIDTH-1]};
    qb  = (rem >= {1'b0, src_opd});
    if (qb) rem = rem - {1'b0, src_opd};
    if (src_mode == IT_MUL) begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], src_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = rem[WIDTH-1:0];
      nxt_lo = {src_lo[WIDTH-2:0], qb};
    end
  end

  // Iteration registers and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      mode_q <= IT_MUL;
    end else if (start) begin
      hi_q   <= nxt_hi;
      lo_q   <= nxt_lo;
      opd_q  <= src_opd;
      mode_q <= mode;
      cnt_q  <= CNT_W'(1);
      run_q  <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == CNT_W'(WIDTH)) begin
        run_q <= 1'b0;
      end else begin
        hi_q  <= nxt_hi;
        lo_q  <= nxt_lo;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign done = run_q && (cnt_q == CNT_W'(WIDTH));
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: handshake FSM, single-cycle ops, flag generation.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  seq_alu_if.slave    bus
);

  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  alu_state_t       state;
  logic [4:0]       opc_q;
  alu_op_t          op_in;
  logic [WIDTH-1:0] sc_res, mc_res, it_lo, it_hi;
  logic [WIDTH:0]   sum;
  logic             sc_c, sc_err, shift_big, go_multi, start, it_done, mc_c;

  assign op_in    = alu_op_t'(bus.opcode);
  // Divide by zero bypasses the iterator and resolves on the single-cycle path.
  assign go_multi = is_multicycle(op_in) && ((op_in == OP_MUL) || (bus.op2 != '0));
  assign start    = (state == IDLE) && bus.in_valid && go_multi;

  // Single-cycle result, including divide-by-zero and illegal-opcode cases.
  always_comb begin
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_err    = 1'b0;
    sum       = {1'b0, bus.op1} + {1'b0, bus.op2};
    shift_big = (bus.op2 >= WLIM);
    case (op_in)
      OP_ADD: begin sc_res = sum[WIDTH-1:0]; sc_c = sum[WIDTH]; end
      OP_SUB: begin sc_res = bus.op1 - bus.op2; sc_c = (bus.op1 < bus.op2); end
      OP_AND: sc_res = bus.op1 & bus.op2;
      OP_OR:  sc_res = bus.op1 | bus.op2;
      OP_XOR: sc_res = bus.op1 ^ bus.op2;
      OP_NOT: sc_res = ~bus.op1;
      OP_SHL: sc_res = shift_big ? '0 : (bus.op1 << bus.op2);
      OP_SHR: sc_res = shift_big ? '0 : (bus.op1 >> bus.op2);
      OP_SAR: sc_res = shift_big ? {WIDTH{bus.op1[WIDTH-1]}}
                                 : $unsigned($signed(bus.op1) >>> bus.op2);
      OP_MUL: sc_res = '0;
      OP_DIV: begin sc_res = '1; sc_err = 1'b1; end
      OP_MOD: begin sc_res = bus.op1; sc_err = 1'b1; end
      default: sc_err = 1'b1;
    endcase
  end

  seq_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  ((op_in == OP_MUL) ? IT_MUL : IT_DIV),
    .a     (bus.op1),
    .b     (bus.op2),
    .done  (it_done),
    .lo    (it_lo),
    .hi    (it_hi)
  );

  assign mc_res = (opc_q == OP_MOD) ? it_hi : it_lo;
  assign mc_c   = (opc_q == OP_MUL) && (it_hi != '0);

  // Control FSM and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      opc_q   <= '0;
      bus.res <= '0;
      bus.s   <= 1'b0;
      bus.g   <= 1'b0;
      bus.z   <= 1'b0;
      bus.c   <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          opc_q <= bus.opcode;
          bus.g <= (bus.op1 > bus.op2);
          if (go_multi) begin
            state <= BUSY;
          end else begin
            state   <= DONE;
            bus.res <= sc_res;
            bus.s   <= sc_res[WIDTH-1];
            bus.z   <= (sc_res == '0);
            bus.c   <= sc_c;
            bus.err <= sc_err;
          end
        end
        BUSY: if (it_done) begin
          state   <= DONE;
          bus.res <= mc_res;
          bus.s   <= mc_res[WIDTH-1];
          bus.z   <= (mc_res == '0);
          bus.c   <= mc_c;
          bus.err <= 1'b0;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=10 and WIDTH=16.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(10)) if10 ();
  seq_alu_if #(.WIDTH(16)) if16 ();

  seq_alu #(.WIDTH(10)) u10 (.clk(clk), .rst(rst), .bus(if10));
  seq_alu #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic [4:0]  opc;
    int unsigned a;
    int unsigned b;
    int unsigned res;
    logic [4:0]  flags;   // {s, g, z, c, err}
    int          lat;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic outv(bit w16);
    return w16 ? if16.out_valid : if10.out_valid;
  endfunction

  function automatic logic inr(bit w16);
    return w16 ? if16.in_ready : if10.in_ready;
  endfunction

  function automatic logic [31:0] rres(bit w16);
    return w16 ? 32'(if16.res) : 32'(if10.res);
  endfunction

  function automatic logic [4:0] rflags(bit w16);
    return w16 ? {if16.s, if16.g, if16.z, if16.c, if16.err}
               : {if10.s, if10.g, if10.z, if10.c, if10.err};
  endfunction

  task automatic drive(input bit w16, input logic v, input logic [4:0] opc,
                       input int unsigned a, input int unsigned b);
    if (w16) begin
      if16.in_valid = v; if16.opcode = opc; if16.op1 = 16'(a); if16.op2 = 16'(b);
    end else begin
      if10.in_valid = v; if10.opcode = opc; if10.op1 = 10'(a); if10.op2 = 10'(b);
    end
  endtask

  // Issue one operation, return cycles from accept until out_valid is seen.
  task automatic do_op(input bit w16, input logic [4:0] opc,
                       input int unsigned a, input int unsigned b, output int lat);
    int guard = 0;
    @(negedge clk);
    drive(w16, 1'b1, opc, a, b);
    while (!inr(w16) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    drive(w16, 1'b0, opc, a, b);
    lat = 1;
    while (!outv(w16) && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out(input bit w16);
    @(negedge clk);
    if (w16) if16.out_ready = 1'b1; else if10.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (w16) if16.out_ready = 1'b0; else if10.out_ready = 1'b0;
  endtask

  task automatic run_chk(input string nm, input bit w16, input logic [4:0] opc,
                         input int unsigned a, input int unsigned b,
                         input int unsigned er, input logic [4:0] ef, input int el);
    int lat;
    do_op(w16, opc, a, b, lat);
    chk({nm, ".lat"}, 32'(lat), 32'(el));
    chk({nm, ".valid"}, 32'(outv(w16)), 32'd1);
    chk({nm, ".res"}, rres(w16), er);
    chk({nm, ".flags"}, 32'(rflags(w16)), 32'(ef));
    release_out(w16);
  endtask

  initial begin
    int lat;
    //          opc       a       b      res     {s,g,z,c,e} lat
    vt[0]  = '{OP_ADD,   2,      4,      6,      5'b00000, 1};
    vt[1]  = '{OP_SUB,   2,      4,      'h3FE,  5'b10010, 1};
    vt[2]  = '{OP_SUB,   4,      4,      0,      5'b00100, 1};
    vt[3]  = '{OP_MUL,   25,     30,     750,    5'b10000, 11};
    vt[4]  = '{OP_MUL,   100,    20,     976,    5'b11010, 11};
    vt[5]  = '{OP_DIV,   100,    7,      14,     5'b01000, 11};
    vt[6]  = '{OP_MOD,   100,    7,      2,      5'b01000, 11};
    vt[7]  = '{OP_DIV,   5,      0,      'h3FF,  5'b11001, 1};
    vt[8]  = '{OP_MOD,   5,      0,      5,      5'b01001, 1};
    vt[9]  = '{OP_SHL,   1,      12,     0,      5'b00100, 1};
    vt[10] = '{OP_SAR,   'h200,  15,     'h3FF,  5'b11000, 1};
    vt[11] = '{5'b11111, 3,      1,      0,      5'b01101, 1};
    vt[12] = '{OP_AND,   'h0F0,  'h3C3,  'h0C0,  5'b00000, 1};
    vt[13] = '{OP_OR,    'h0F0,  'h30F,  'h3FF,  5'b10000, 1};
    vt[14] = '{OP_XOR,   'h3FF,  'h0F0,  'h30F,  5'b11000, 1};
    vt[15] = '{OP_NOT,   'h155,  0,      'h2AA,  5'b11000, 1};
    vt[16] = '{OP_SHR,   'h300,  4,      'h030,  5'b01000, 1};
    vt[17] = '{OP_ADD,   'h3FF,  1,      0,      5'b01110, 1};
    vt[18] = '{OP_SAR,   'h2F0,  2,      'h3BC,  5'b11000, 1};
    vt[19] = '{OP_SHL,   1,      9,      'h200,  5'b10000, 1};
    vt[20] = '{OP_DIV,   1023,   1,      1023,   5'b11000, 11};
    vt[21] = '{5'b00000, 0,      0,      0,      5'b00101, 1};
    vt[22] = '{OP_MOD,   1023,   1000,   23,     5'b01000, 11};

    drive(1'b0, 1'b0, 5'd0, 0, 0);
    drive(1'b1, 1'b0, 5'd0, 0, 0);
    if10.out_ready = 1'b0;
    if16.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(if10.in_ready), 32'd1);
    chk("rst.out_valid", 32'(if10.out_valid), 32'd0);
    chk("rst.res", rres(1'b0), 32'd0);
    chk("rst.flags", 32'(rflags(1'b0)), 32'd0);
    chk("rst16.in_ready", 32'(if16.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++)
      run_chk($sformatf("v%0d", i), 1'b0, vt[i].opc, vt[i].a, vt[i].b,
              vt[i].res, vt[i].flags, vt[i].lat);

    // Backpressure: result held while out_ready is low.
    do_op(1'b0, OP_SHL, 1, 3, lat);
    chk("bp.lat", 32'(lat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp.res%0d", k), rres(1'b0), 32'd8);
      chk($sformatf("bp.in_ready%0d", k), 32'(if10.in_ready), 32'd0);
      chk($sformatf("bp.valid%0d", k), 32'(if10.out_valid), 32'd1);
    end
    @(negedge clk);
    if10.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if10.out_ready = 1'b0;
    chk("bp.in_ready_after", 32'(if10.in_ready), 32'd1);
    chk("bp.valid_after", 32'(if10.out_valid), 32'd0);

    // Reset during BUSY aborts the multiply with no output.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 30, 25);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, OP_MUL, 30, 25);
    chk("abort.busy", 32'(if10.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.in_ready", 32'(if10.in_ready), 32'd1);
    chk("abort.valid", 32'(if10.out_valid), 32'd0);
    chk("abort.res", rres(1'b0), 32'd0);
    chk("abort.flags", 32'(rflags(1'b0)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort.no_output", 32'(if10.out_valid), 32'd0);
    run_chk("after_abort", 1'b0, OP_MUL, 25, 30, 750, 5'b10000, 11);

    // WIDTH=16 instance.
    run_chk("w16.mul", 1'b1, OP_MUL, 300, 200, 60000, 5'b11000, 17);
    run_chk("w16.div", 1'b1, OP_DIV, 60000, 7, 8571, 5'b01000, 17);
    run_chk("w16.mod", 1'b1, OP_MOD, 60000, 7, 3, 5'b01000, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
